// File: rtl/serial_word_tx_if.sv
// Word-in / bit-out bundle for serial_word_tx: valid/ready word handshake,
// abort, serial stream and the per-word reference flags.
interface serial_word_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             abort;
  logic             out;
  logic             bit_valid;
  logic             last_bit;
  logic             done;
  logic             mult4;

  modport master (
    output in_valid, data_in, abort,
    input  in_ready, out, bit_valid, last_bit, done, mult4
  );

  modport slave (
    input  in_valid, data_in, abort,
    output in_ready, out, bit_valid, last_bit, done, mult4
  );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word, shifts it out
// MSB-first one bit per clock, then pulses done with the word's mod-4 flag.
module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  serial_word_tx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             mult4_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; reset is asynchronous and clears all state immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = SHIFT;
      SHIFT: begin
        // abort outranks the final-bit transition
        if (bus.abort)       state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= '0;
      cnt     <= '0;
      mult4_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg    <= bus.data_in;
            cnt     <= CW'(WIDTH - 1);
            mult4_q <= ~|bus.data_in[1:0];
          end
        end
        SHIFT: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Every output is a decode of registered state, so reset clears them at once
  // and no input reaches an output combinationally.
  assign bus.in_ready  = (state == IDLE);
  assign bus.bit_valid = (state == SHIFT);
  assign bus.out       = (state == SHIFT) && sreg[WIDTH-1];
  assign bus.last_bit  = (state == SHIFT) && (cnt == '0);
  assign bus.done      = (state == DONE);
  assign bus.mult4     = (state == DONE) && mult4_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx (WIDTH=8): streams, back-to-back spacing,
// abort, asynchronous reset mid-word and a mod-4 detector loopback.
module tb_serial_word_tx;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   ones_cnt = 0;
  int   done_cnt = 0;
  logic [1:0] det;

  serial_word_tx_if #(.WIDTH(8)) bus ();

  serial_word_tx #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.bit_valid && bus.out) ones_cnt <= ones_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  // Independent multiple-of-4 detector: residue of an MSB-first stream is
  // (2r + b) mod 4, i.e. the last two bits seen.
  always @(posedge clk or negedge reset) begin
    if (!reset)             det <= 2'b00;
    else if (bus.bit_valid) det <= {det[0], bus.out};
    else if (bus.done)      det <= 2'b00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge in IDLE, ends at a negedge in IDLE after done.
  task automatic xfer(input string tag, input logic [7:0] word, input logic [7:0] stream,
                      input logic m4, input bit hold_valid);
    check({tag, " ready"}, 32'(bus.in_ready), 32'd1);
    bus.data_in  = word;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (!hold_valid) bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("%s bv%0d", tag, i),   32'(bus.bit_valid), 32'd1);
      check($sformatf("%s out%0d", tag, i),  32'(bus.out),       32'(stream[7-i]));
      check($sformatf("%s last%0d", tag, i), 32'(bus.last_bit),  32'(i == 7));
      check($sformatf("%s rdy%0d", tag, i),  32'(bus.in_ready),  32'd0);
    end
    @(negedge clk);
    check({tag, " done"},     32'(bus.done),      32'd1);
    check({tag, " mult4"},    32'(bus.mult4),     32'(m4));
    check({tag, " det"},      32'(bus.mult4),     32'(det == 2'b00));
    check({tag, " bv_off"},   32'(bus.bit_valid), 32'd0);
    check({tag, " out_off"},  32'(bus.out),       32'd0);
    @(negedge clk);
    check({tag, " rdy_back"}, 32'(bus.in_ready),  32'd1);
    check({tag, " done_off"}, 32'(bus.done),      32'd0);
    check({tag, " m4_off"},   32'(bus.mult4),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int ones0;
    int done0;
    logic [15:0] m4_tab;
    m4_tab = 16'b0001_0001_0001_0001;

    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.abort    = 1'b0;
    #1;
    check("rst in_ready", 32'(bus.in_ready),  32'd1);
    check("rst out",      32'(bus.out),       32'd0);
    check("rst bv",       32'(bus.bit_valid), 32'd0);
    check("rst last",     32'(bus.last_bit),  32'd0);
    check("rst done",     32'(bus.done),      32'd0);
    check("rst mult4",    32'(bus.mult4),     32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    xfer("b4", 8'hB4, 8'b1011_0100, 1'b1, 1'b0);
    xfer("6d", 8'h6D, 8'b0110_1101, 1'b0, 1'b0);

    // Back-to-back with in_valid held high across both words
    xfer("b2b04", 8'h04, 8'b0000_0100, 1'b1, 1'b1);
    acc1 = last_acc;
    xfer("b2b03", 8'h03, 8'b0000_0011, 1'b0, 1'b0);
    check("b2b spacing", 32'(last_acc - acc1), 32'd10);

    // Abort during the 4th bit of 0xFF
    ones0 = ones_cnt;
    done0 = done_cnt;
    bus.data_in  = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort pre_bv", 32'(bus.bit_valid), 32'd1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort bv_drop", 32'(bus.bit_valid), 32'd0);
    check("abort ready",   32'(bus.in_ready),  32'd1);
    check("abort done",    32'(bus.done),      32'd0);
    repeat (3) @(negedge clk);
    check("abort ones",    32'(ones_cnt - ones0), 32'd4);
    check("abort no_done", 32'(done_cnt - done0), 32'd0);

    // Asynchronous reset between edges while shifting 0xA5 (third bit is 1)
    bus.data_in  = 8'hA5;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid pre_out", 32'(bus.out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid out",   32'(bus.out),       32'd0);
    check("mid bv",    32'(bus.bit_valid), 32'd0);
    check("mid last",  32'(bus.last_bit),  32'd0);
    check("mid ready", 32'(bus.in_ready),  32'd1);
    check("mid done",  32'(bus.done),      32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    xfer("post10", 8'h10, 8'b0001_0000, 1'b1, 1'b0);

    // Loopback of 0x00..0x0F against the detector and a hand table
    for (int w = 0; w < 16; w++) begin
      xfer($sformatf("lb%0h", w), 8'(w), 8'(w), m4_tab[w], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial bit-stream transmitter. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a single serial line. It is the driving end for the team's serial bit-stream detectors (multiple-of-N, sequence detectors). Alongside the stream it emits a reference flag, the word's own multiple-of-4 status, so a bench or checker can compare it against a downstream detector.

## Interface
Parameters:
- WIDTH, default 8: word width in bits; legal values are 2 to 32.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: data_in holds a word to send.
- in_ready, output, 1: block can accept a word; high only in IDLE.
- data_in, input, WIDTH: word to transmit; sampled on the accept edge.
- abort, input, 1: cancels a transfer in progress.
- out, output, 1: serial data, MSB-first.
- bit_valid, output, 1: out carries a live bit this cycle.
- last_bit, output, 1: high together with the final (LSB) bit.
- done, output, 1: one-cycle pulse after the LSB has been sent.
- mult4, output, 1: (transmitted word mod 4 == 0); valid only while done=1, otherwise 0.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out=0, bit_valid=0.
  - On a rising edge with in_valid=1, the word is accepted: shift register <= data_in, bit counter <= WIDTH-1, next state SHIFT.
- SHIFT:
  - out = shift register MSB; bit_valid=1.
  - Each edge: shift left by 1 with 0 fill, decrement the counter.
  - last_bit=1 when counter==0; that edge moves to DONE.
- DONE (one cycle):
  - done=1, mult4 = ~|word[1:0] of the accepted word (captured at accept), out=0, bit_valid=0.
  - Next state IDLE unconditionally.
- abort:
  - Sampled in SHIFT only; ignored in IDLE and DONE.
  - abort=1 at an edge in SHIFT forces IDLE at that edge. No DONE, no done pulse; the remaining bits are dropped.
  - abort takes priority over the last-bit transition.
- in_valid is ignored outside IDLE; words are not queued. The upstream must hold in_valid until it sees in_ready=1.
- The counter is $clog2(WIDTH) bits wide and never wraps below 0. The SHIFT→DONE transition happens before any wrap.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, shift register=0, counter=0.
  - Outputs: in_ready=1, out=0, bit_valid=0, last_bit=0, done=0, mult4=0.
  - Reset asserted mid-SHIFT or in DONE clears outputs immediately, without waiting for a clock edge.
  - Release of reset is synchronous to clk: the first accept happens no earlier than the first rising edge after release.
- Accept at edge k: MSB appears on out during cycle k+1 (latency 1). Bit i (MSB=0) appears in cycle k+1+i.
- LSB appears in cycle k+WIDTH with last_bit=1. done/mult4 appear in cycle k+WIDTH+1. in_ready is back to 1 in cycle k+WIDTH+2.
- Minimum spacing between accepts is WIDTH+2 cycles.
- bit_valid is high for exactly WIDTH consecutive cycles per completed word; fewer on abort.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then WIDTH=8, data_in=8'hB4, in_valid for one cycle in IDLE:
  - out = 1,0,1,1,0,1,0,0 on 8 consecutive bit_valid cycles, last_bit on the 8th.
  - Next cycle done=1, mult4=1; in_ready=1 one cycle later.
- data_in=8'h6D: stream 0,1,1,0,1,1,0,1 → done with mult4=0.
- Back-to-back: hold in_valid=1 with 8'h04 then 8'h03:
  - Second accept happens exactly 10 cycles after the first.
  - mult4=1 then mult4=0; no bit_valid gap other than the DONE and IDLE cycles.
- abort=1 during the 4th bit of 8'hFF:
  - bit_valid drops at the next cycle and only 4 ones are sent.
  - No done pulse; in_ready=1 the cycle after the abort edge.
- reset driven low mid-SHIFT (between clock edges):
  - out, bit_valid, last_bit drop to 0 and in_ready rises to 1 immediately.
  - After release, 8'h10 is sent cleanly with mult4=1.
- Loopback: connect out/bit_valid to the multiple-of-4 detector and send words 0x00..0x0F:
  - At every done, the detector output after the last bit equals mult4 (1 for 0,4,8,C).
